// File: rtl/disp_hex_demux.sv
// Recovers four hex digits plus decimal points from a multiplexed active-low
// seven-segment bus; a slot is captured once its pins have settled.
module disp_hex_demux #(
  parameter int STABLE_CYCLES = 16,
  parameter int TIMEOUT_BITS  = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] an,
  input  logic [7:0] sseg,
  output logic [3:0] hex0,
  output logic [3:0] hex1,
  output logic [3:0] hex2,
  output logic [3:0] hex3,
  output logic [3:0] dp_out,
  output logic [3:0] valid,
  output logic [3:0] seg_err,
  output logic       frame_tick
);

  localparam int CW = (STABLE_CYCLES <= 2) ? 1 : $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0]           CNT_MAX = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0]           CNT_ONE = CW'(1);
  localparam logic [TIMEOUT_BITS-1:0] TMO_ONE = TIMEOUT_BITS'(1);

  logic [11:0]             s1_q, s2_q, s2_prev_q;
  logic [CW-1:0]           cnt_q;
  logic                    captured_q;
  logic                    cap_vld_q;
  logic [1:0]              cap_slot_q;
  logic [3:0]              cap_nib_q;
  logic                    cap_dp_q;
  logic                    cap_err_q;
  logic [3:0]              hex_q [4];
  logic [3:0]              dp_q, valid_q, err_q, mask_q;
  logic                    tick_q;
  logic [TIMEOUT_BITS-1:0] tmo_q;

  logic                    one_hot, same, cnt_clr, cap_d;
  logic [1:0]              slot;
  logic [4:0]              dec;
  logic [3:0]              mask_d;

  // Returns {illegal, nibble}; illegal patterns decode to nibble 0.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'b1000000: return 5'h00;
      7'b1111001: return 5'h01;
      7'b0100100: return 5'h02;
      7'b0110000: return 5'h03;
      7'b0011001: return 5'h04;
      7'b0010010: return 5'h05;
      7'b0000010: return 5'h06;
      7'b1111000: return 5'h07;
      7'b0000000: return 5'h08;
      7'b0010000: return 5'h09;
      7'b0001000: return 5'h0A;
      7'b0000011: return 5'h0B;
      7'b1000110: return 5'h0C;
      7'b0100001: return 5'h0D;
      7'b0000110: return 5'h0E;
      7'b0001110: return 5'h0F;
      default:    return 5'h10;
    endcase
  endfunction

  always_comb begin
    one_hot = 1'b1;
    slot    = 2'd0;
    case (s2_q[11:8])
      4'b1110: slot = 2'd0;
      4'b1101: slot = 2'd1;
      4'b1011: slot = 2'd2;
      4'b0111: slot = 2'd3;
      default: one_hot = 1'b0;
    endcase
    same    = (s2_q == s2_prev_q);
    cnt_clr = !same || !one_hot;
    cap_d   = !cnt_clr && (cnt_q == CNT_MAX) && !captured_q;
    dec     = decode(s2_q[6:0]);
    mask_d  = mask_q | (4'b0001 << cap_slot_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q       <= '0;
      s2_q       <= '0;
      s2_prev_q  <= '0;
      cnt_q      <= '0;
      captured_q <= 1'b0;
      cap_vld_q  <= 1'b0;
      cap_slot_q <= '0;
      cap_nib_q  <= '0;
      cap_dp_q   <= 1'b0;
      cap_err_q  <= 1'b0;
      for (int i = 0; i < 4; i++) hex_q[i] <= '0;
      dp_q       <= '0;
      valid_q    <= '0;
      err_q      <= '0;
      mask_q     <= '0;
      tick_q     <= 1'b0;
      tmo_q      <= '0;
    end else begin
      s1_q      <= {an, sseg};
      s2_q      <= s1_q;
      s2_prev_q <= s2_q;

      if (cnt_clr) begin
        cnt_q      <= '0;
        captured_q <= 1'b0;
      end else begin
        if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_ONE;
        if (cap_d) captured_q <= 1'b1;
      end

      // Decision and decode are staged one cycle ahead of the output update.
      cap_vld_q <= cap_d;
      if (cap_d) begin
        cap_slot_q <= slot;
        cap_nib_q  <= dec[3:0];
        cap_dp_q   <= s2_q[7];
        cap_err_q  <= dec[4];
      end

      tick_q <= 1'b0;
      if (cap_vld_q) begin
        hex_q[cap_slot_q]   <= cap_nib_q;
        dp_q[cap_slot_q]    <= cap_dp_q;
        valid_q[cap_slot_q] <= 1'b1;
        err_q[cap_slot_q]   <= cap_err_q;
        tmo_q               <= '0;
        if (mask_d == 4'hF) begin
          mask_q <= '0;
          tick_q <= 1'b1;
        end else begin
          mask_q <= mask_d;
        end
      end else if (tmo_q == '1) begin
        valid_q <= '0;
        mask_q  <= '0;
        tmo_q   <= '0;
      end else begin
        tmo_q <= tmo_q + TMO_ONE;
      end
    end
  end

  assign hex0       = hex_q[0];
  assign hex1       = hex_q[1];
  assign hex2       = hex_q[2];
  assign hex3       = hex_q[3];
  assign dp_out     = dp_q;
  assign valid      = valid_q;
  assign seg_err    = err_q;
  assign frame_tick = tick_q;

endmodule

// File: doc/disp_hex_demux.md
Name: disp_hex_demux

Overview:
Receive end of the multiplexed 4-digit seven-segment interface driven by disp_hex_mux. It samples the time-multiplexed an/sseg lines, waits for each anode slot to settle, and decodes the active-low segment pattern back into a hex nibble and a decimal-point bit per digit. Used for self-checking display benches and on-board loopback tests that capture another board's display pins.

Parameters:
STABLE_CYCLES, 16, consecutive identical synchronized samples required before a digit is captured (min 2)
TIMEOUT_BITS, 20, width of the inactivity counter; valid flags clear after 2^TIMEOUT_BITS-1 cycles without a capture

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
an  input  4  anode enables, active low, one-hot-low when a digit is lit
sseg  input  8  segments, active low; [7]=dp, [6:0]=g..a (bit0=a)
hex0  output  4  decoded digit 0 (an[0] slot); hex1..hex3 are identical for slots 1..3
hex1  output  4  decoded digit 1
hex2  output  4  decoded digit 2
hex3  output  4  decoded digit 3
dp_out  output  4  raw sseg[7] level captured per digit (1 = dp off)
valid  output  4  digit k captured since reset or last timeout
seg_err  output  4  last capture of digit k was not a legal hex pattern
frame_tick  output  1  one-cycle pulse when all four digits have been refreshed

Behaviour:
- Clocking: single clk domain. Reset is asynchronous and active-high. Reset clears all registers; every output is 0.
- Input sync: {an,sseg} passes through a 2-flop synchronizer (s2), then a compare register (s2_prev).
- Stability counter cnt:
  - cleared when s2 != s2_prev, or when an is not one-hot-low (1111, or two or more zeros)
  - otherwise increments, saturating at STABLE_CYCLES-1
- Capture condition: cnt == STABLE_CYCLES-1, s2 == s2_prev, and slot not yet captured.
  - A captured flag blocks recapture of the same settled value. It clears whenever cnt clears.
- Capture latency: pins change then hold before edge 0 -> hex/dp/valid/seg_err update at edge STABLE_CYCLES+3.
- Capture for slot k (k = index of the zero in an):
  - hex_k <= decoded nibble, dp_out[k] <= sseg[7], valid[k] <= 1
  - seg_err[k] <= 1 if the pattern is illegal, else 0
  - other slots are unchanged
- Decode table, sseg[6:0] active low:
  0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000,
  8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
  Any other pattern -> hex_k = 0, seg_err[k] = 1.
- Refresh mask (4 bits):
  - each capture ORs in bit k
  - when a capture makes the mask 1111: frame_tick = 1 on the same edge as that capture, mask clears, frame_tick = 0 next cycle
  - recapturing an already-set slot does not reset the mask
- Timeout counter (TIMEOUT_BITS wide):
  - increments every cycle and clears on every capture
  - at all-ones: valid <= 0, mask <= 0, counter <= 0
  - hex/dp_out/seg_err keep their last values
  - if a capture and expiry fall on the same cycle, the capture wins: counter clears and valid[k] = 1
- Glitches shorter than STABLE_CYCLES produce no capture.
- Reset asserted mid-capture clears everything immediately; no partial update.

Test Plan:
- Reset asserted with arbitrary inputs -> all outputs 0; after release, an=1111 held 100 cycles -> outputs stay 0.
- STABLE_CYCLES=4; an=1110, sseg=1_0010010 held 20 cycles -> hex0=5, dp_out=0001, valid=0001, seg_err=0, update exactly at edge 7.
- an=1101, sseg=0_1111000 for 3 cycles, then an=1111 -> no change; repeat with a hold of 10 cycles -> hex1=7, dp_out[1]=0.
- Scan an=1110/1101/1011/0111 with digits A,3,0,F, 10 cycles each -> hex3..0 = F,0,3,A, valid=1111, exactly one frame_tick coinciding with the slot-3 capture.
- an=1011 with sseg[6:0]=1111111 (blank), then 0101010 -> hex2=0, seg_err[2]=1; then a legal '9' -> seg_err[2]=0, hex2=9.
- TIMEOUT_BITS=6, capture one digit, then an=1111 -> valid clears after 63 cycles and hex is retained; reset pulsed mid-hold -> immediate clear.
